// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the nibble-CPU control sequencer: FSM states, opcodes,
// ALU selects and the bit layout of the decoded control vector.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_JC    = 4'b0000;
  localparam logic [3:0] OP_JNC   = 4'b0001;
  localparam logic [3:0] OP_CMPI  = 4'b0010;
  localparam logic [3:0] OP_CMPM  = 4'b0011;
  localparam logic [3:0] OP_LIT   = 4'b0100;
  localparam logic [3:0] OP_IN    = 4'b0101;
  localparam logic [3:0] OP_LD    = 4'b0110;
  localparam logic [3:0] OP_ST    = 4'b0111;
  localparam logic [3:0] OP_JZ    = 4'b1000;
  localparam logic [3:0] OP_JNZ   = 4'b1001;
  localparam logic [3:0] OP_ADDI  = 4'b1010;
  localparam logic [3:0] OP_ADDM  = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_OUT   = 4'b1101;
  localparam logic [3:0] OP_NANDI = 4'b1110;
  localparam logic [3:0] OP_NANDM = 4'b1111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_CMP  = 3'b001;
  localparam logic [2:0] ALU_LOAD = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_NAND = 3'b100;

  // Commit bits occupy the low six positions so a single mask can gate them.
  localparam int CV_W          = 13;
  localparam int CV_INC_PC     = 0;
  localparam int CV_LOAD_PC    = 1;
  localparam int CV_LOAD_A     = 2;
  localparam int CV_LOAD_FLAGS = 3;
  localparam int CV_WE_RAM     = 4;
  localparam int CV_LOAD_OUT   = 5;
  localparam int CV_SEL_LSB    = 6;
  localparam int CV_CS_RAM     = 9;
  localparam int CV_OE_ALU     = 10;
  localparam int CV_OE_IN      = 11;
  localparam int CV_OE_OPRND   = 12;

  localparam logic [CV_W-1:0] CV_COMMIT_MASK = 13'h003F;

  function automatic logic is_ram_op(input logic [3:0] op);
    case (op)
      OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NANDM: is_ram_op = 1'b1;
      default:                                  is_ram_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode_rom.sv
// Combinational opcode + flag decode into the full control vector, ignoring
// cycle position; the sequencer gates the commit bits.
module ctrl_decode_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0]      instr,
  input  logic            c_flag,
  input  logic            z_flag,
  output logic [CV_W-1:0] cv
);

  logic taken;

  // Branch condition evaluated against the registered (pre-update) flags.
  always_comb begin
    case (instr)
      OP_JC:   taken = c_flag;
      OP_JNC:  taken = ~c_flag;
      OP_JZ:   taken = z_flag;
      OP_JNZ:  taken = ~z_flag;
      default: taken = 1'b0;
    endcase
  end

  // Opcode table.
  always_comb begin
    cv = '0;
    case (instr)
      OP_JC, OP_JNC, OP_JZ, OP_JNZ: begin
        cv[CV_LOAD_PC] = taken;
        cv[CV_INC_PC]  = ~taken;
        cv[CV_OE_ALU]  = 1'b1;
      end
      OP_JMP: begin
        cv[CV_LOAD_PC] = 1'b1;
        cv[CV_OE_ALU]  = 1'b1;
      end
      OP_CMPI: begin
        cv[CV_LOAD_FLAGS]        = 1'b1;
        cv[CV_SEL_LSB +: 3]      = ALU_CMP;
        cv[CV_OE_OPRND]          = 1'b1;
      end
      OP_CMPM: begin
        cv[CV_INC_PC]            = 1'b1;
        cv[CV_LOAD_FLAGS]        = 1'b1;
        cv[CV_SEL_LSB +: 3]      = ALU_CMP;
        cv[CV_CS_RAM]            = 1'b1;
      end
      OP_LIT, OP_IN: begin
        cv[CV_LOAD_A]            = 1'b1;
        cv[CV_LOAD_FLAGS]        = 1'b1;
        cv[CV_SEL_LSB +: 3]      = ALU_LOAD;
        cv[CV_OE_OPRND]          = (instr == OP_LIT);
        cv[CV_OE_IN]             = (instr == OP_IN);
      end
      OP_LD: begin
        cv[CV_INC_PC]            = 1'b1;
        cv[CV_LOAD_A]            = 1'b1;
        cv[CV_LOAD_FLAGS]        = 1'b1;
        cv[CV_SEL_LSB +: 3]      = ALU_LOAD;
        cv[CV_CS_RAM]            = 1'b1;
      end
      OP_ST: begin
        cv[CV_INC_PC]            = 1'b1;
        cv[CV_CS_RAM]            = 1'b1;
        cv[CV_WE_RAM]            = 1'b1;
        cv[CV_OE_ALU]            = 1'b1;
      end
      OP_ADDI, OP_NANDI: begin
        cv[CV_LOAD_A]            = 1'b1;
        cv[CV_LOAD_FLAGS]        = 1'b1;
        cv[CV_SEL_LSB +: 3]      = (instr == OP_ADDI) ? ALU_ADD : ALU_NAND;
        cv[CV_OE_OPRND]          = 1'b1;
      end
      OP_ADDM, OP_NANDM: begin
        cv[CV_INC_PC]            = 1'b1;
        cv[CV_LOAD_A]            = 1'b1;
        cv[CV_LOAD_FLAGS]        = 1'b1;
        cv[CV_SEL_LSB +: 3]      = (instr == OP_ADDM) ? ALU_ADD : ALU_NAND;
        cv[CV_CS_RAM]            = 1'b1;
      end
      OP_OUT: begin
        cv[CV_OE_ALU]            = 1'b1;
        cv[CV_LOAD_OUT]          = 1'b1;
      end
      default: cv = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute sequencer for the nibble CPU: owns phase, RAM wait stretching
// and the C/Z flag register; outputs decode combinationally from that state.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int RAM_WAIT = 0,
  parameter int CNT_W    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] instr,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       load_instr,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_a,
  output logic       load_flags,
  output logic [2:0] alu_sel,
  output logic       cs_ram,
  output logic       we_ram,
  output logic       oe_alu,
  output logic       oe_in,
  output logic       oe_oprnd,
  output logic       load_out,
  output logic       phase,
  output logic       c_flag,
  output logic       z_flag,
  output logic       instr_done
);

  localparam logic             HAS_WAIT  = 1'(RAM_WAIT > 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((RAM_WAIT > 0) ? RAM_WAIT - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CV_W-1:0]  cv;
  logic [CV_W-1:0]  ctl;
  logic             stretch;
  logic             in_exec;
  logic             last_cycle;
  logic             fetch_go;

  ctrl_decode_rom u_rom (
    .instr  (instr),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .cv     (cv)
  );

  // Cycle-position terms; reset hides the execute phase entirely.
  always_comb begin
    stretch  = HAS_WAIT & is_ram_op(instr);
    in_exec  = ((state == EXEC) || (state == WAIT)) && !reset;
    fetch_go = (state == FETCH) && run && !reset;
    case (state)
      EXEC:    last_cycle = in_exec && !stretch;
      WAIT:    last_cycle = in_exec && (cnt == '0);
      default: last_cycle = 1'b0;
    endcase
  end

  // Steering bits track every execute cycle; commit bits only the final one.
  always_comb begin
    if (in_exec) begin
      if (last_cycle) ctl = cv;
      else            ctl = cv & ~CV_COMMIT_MASK;
    end else begin
      ctl            = '0;
      ctl[CV_OE_ALU] = 1'b1;
      ctl[CV_INC_PC] = fetch_go;
    end
  end

  assign load_instr = fetch_go;
  assign inc_pc     = ctl[CV_INC_PC];
  assign load_pc    = ctl[CV_LOAD_PC];
  assign load_a     = ctl[CV_LOAD_A];
  assign load_flags = ctl[CV_LOAD_FLAGS];
  assign we_ram     = ctl[CV_WE_RAM];
  assign load_out   = ctl[CV_LOAD_OUT];
  assign alu_sel    = ctl[CV_SEL_LSB +: 3];
  assign cs_ram     = ctl[CV_CS_RAM];
  assign oe_alu     = ctl[CV_OE_ALU];
  assign oe_in      = ctl[CV_OE_IN];
  assign oe_oprnd   = ctl[CV_OE_OPRND];
  assign phase      = in_exec;
  assign instr_done = last_cycle;

  // Phase FSM, wait counter and flag register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FETCH;
      cnt    <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      if (load_flags) begin
        c_flag <= alu_carry;
        z_flag <= alu_zero;
      end
      case (state)
        FETCH: if (run) state <= EXEC;
        EXEC: begin
          if (stretch) begin
            state <= WAIT;
            cnt   <= WAIT_LOAD;
          end else begin
            state <= FETCH;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= FETCH;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          state <= FETCH;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Registered successor to the combinational nibble-CPU decoder. Owns the fetch/execute phase sequencing internally and holds the C/Z flag register. Stretches RAM-access instructions by a parametrised number of wait cycles. Supports a run/halt control. Sits between the instruction register/ALU and the PC, accumulator, RAM and I/O latches.

Parameters:
RAM_WAIT, 0, extra execute cycles for RAM-access opcodes (legal range 0..7).
CNT_W, 3, width of the internal wait counter; must hold RAM_WAIT.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  1 = sequence instructions; sampled only in FETCH
instr  in  4  opcode from the instruction register
alu_carry  in  1  raw ALU carry; captured on flag commit
alu_zero  in  1  raw ALU zero; captured on flag commit
load_instr  out  1  fetch strobe for the instruction register
inc_pc  out  1  commit strobe
load_pc  out  1  commit strobe
load_a  out  1  commit strobe
load_flags  out  1  commit strobe; also loads the internal flags
alu_sel  out  3  ALU function select
cs_ram  out  1  RAM chip select (steering)
we_ram  out  1  RAM write enable (commit)
oe_alu  out  1  output enable (steering)
oe_in  out  1  output enable (steering)
oe_oprnd  out  1  output enable (steering)
load_out  out  1  commit strobe
phase  out  1  0 in FETCH, 1 in EXEC/WAIT
c_flag  out  1  registered carry flag
z_flag  out  1  registered zero flag
instr_done  out  1  1-cycle pulse on the final execute cycle

Behaviour:
- States:
  - FETCH: if run=1, go to EXEC; else stay.
  - EXEC: if the opcode is a RAM op and RAM_WAIT>0, go to WAIT and load the counter with RAM_WAIT-1; else go to FETCH.
  - WAIT: decrement the counter; go to FETCH when it reaches 0.
- RAM ops: 0011, 0110, 0111, 1011, 1111. With RAM_WAIT=N, a RAM op occupies 1+N execute cycles. All other opcodes take exactly 1 execute cycle.
- FETCH outputs, only when run=1: load_instr=1, inc_pc=1, oe_alu=1. When run=0: all strobes 0, oe_alu=1.
- Execute decode. Unlisted signals are 0. alu_sel is 000 unless stated. Encoding:
  - 0000 JC: load_pc if c_flag else inc_pc; oe_alu.
  - 0001 JNC: load_pc if !c_flag else inc_pc; oe_alu.
  - 1000 JZ / 1001 JNZ: same scheme using z_flag.
  - 1100 JMP: load_pc, oe_alu.
  - 0010 CMPI: load_flags, sel=001, oe_oprnd.
  - 0011 CMPM: inc_pc, load_flags, sel=001, cs_ram.
  - 0100 LIT: load_a, load_flags, sel=010, oe_oprnd.
  - 0101 IN: load_a, load_flags, sel=010, oe_in.
  - 0110 LD: inc_pc, load_a, load_flags, sel=010, cs_ram.
  - 0111 ST: inc_pc, cs_ram, we_ram, oe_alu.
  - 1010 ADDI: load_a, load_flags, sel=011, oe_oprnd.
  - 1011 ADDM: inc_pc, load_a, load_flags, sel=011, cs_ram.
  - 1101 OUT: oe_alu, load_out.
  - 1110 NANDI: load_a, load_flags, sel=100, oe_oprnd.
  - 1111 NANDM: inc_pc, load_a, load_flags, sel=100, cs_ram.
- Multi-cycle rule:
  - Steering signals (alu_sel, cs_ram, oe_*) are held for every execute cycle of the instruction.
  - Commit signals (inc_pc, load_pc, load_a, load_flags, we_ram, load_out) assert only on the final execute cycle, together with instr_done.
- instr is sampled every execute cycle. The instruction register must hold it stable from FETCH until instr_done.
- Flags: on a clock edge with load_flags=1, c_flag<=alu_carry and z_flag<=alu_zero. Jump decisions use the registered flags (the pre-update values).
- run deasserted mid-instruction: the instruction completes, then the block parks in FETCH.
- Reset, including mid-WAIT:
  - Next state FETCH, counter 0, c_flag=0, z_flag=0.
  - While reset=1, all commit strobes and load_instr are forced to 0. Steering outputs show FETCH values (oe_alu=1, others 0), phase=0.
- Outputs are combinational from state, counter, instr and flags. There is no output register, so no added latency.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - State enum (FETCH, EXEC, WAIT).
  - Opcode localparams (OP_JC..OP_NANDM).
  - ALU select localparams (ALU_PASS=000, ALU_CMP=001, ALU_LOAD=010, ALU_ADD=011, ALU_NAND=100).
  - Control-vector bit positions.
- Sub-module ctrl_decode_rom: purely combinational opcode+flags → 13-bit control vector. The sequencer masks commit bits with its last-cycle term.

Test Plan:
- Reset, then run=1, instr=0100 (LIT), alu_carry=1, alu_zero=0 → cycle 1: load_instr=1, inc_pc=1. Cycle 2: load_a=1, load_flags=1, alu_sel=010, oe_oprnd=1, instr_done=1. Afterwards c_flag=1, z_flag=0.
- c_flag=1, instr=0000 → execute cycle: load_pc=1, inc_pc=0. Repeat with c_flag=0 → inc_pc=1, load_pc=0. Same check for 1001 JNZ with z_flag=0 → load_pc=1.
- RAM_WAIT=3, instr=0111 (ST) → 4 execute cycles with cs_ram=1 and oe_alu=1 throughout. we_ram, inc_pc and instr_done are 1 only in the 4th; phase=1 in all 4.
- RAM_WAIT=2, reset asserted in the first WAIT cycle of 1011 → no load_a or inc_pc pulse. Next cycle: FETCH, c_flag=z_flag=0.
- run=0 → FETCH persists with load_instr=0 and inc_pc=0 for 5 cycles. run=1 → fetch strobe on the next cycle.
- Sweep all 16 opcodes × 4 flag combinations at RAM_WAIT=0 → control vector matches the encoding table exactly.
